// File: rtl/fifo_sync_fwft_count_if.sv
// Handshake and status bundle between a producer/consumer and fifo_sync_fwft_count.
// Pure wiring: no latency of its own.
// Backpressure comes from full/empty carried here, not from the interface itself.
interface fifo_sync_fwft_count_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
);
  logic                  clear;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_en;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   af_thresh;
  logic [ADDR_WIDTH:0]   ae_thresh;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  // User side: drives requests and thresholds, observes data and status.
  modport master (
    output clear, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );

  // FIFO side: mirror image of the user side.
  modport slave (
    input  clear, wr_data, wr_en, rd_en, af_thresh, ae_thresh,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_fwft_count.sv
// Single-clock FIFO on an inferred block RAM with occupancy count, thresholds and sticky error flags.
// Latency: standard read data 1 cycle after rd_en; FWFT head word visible 2 cycles after first write.
// Backpressure: writes dropped while full, reads ignored while empty; both flagged sticky.
module fifo_sync_fwft_count #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0
) (
  input  logic clk,
  input  logic rst_n,
  fifo_sync_fwft_count_if.slave bus
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  (* ram_style = "block" *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt;
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  vld_q;
  logic                  ovf_q;
  logic                  udf_q;

  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  ren;
  logic                  vld_nxt;
  logic [ADDR_WIDTH:0]   mem_words;

  // Accept/reject decisions from registered state; ren drives the RAM read port.
  // In FWFT mode the RAM output register is the head stage, so a read there is a prefetch.
  always_comb begin
    full_w    = (cnt == DEPTH_CNT);
    empty_w   = (FWFT != 0) ? !vld_q : (cnt == '0);
    wr_acc    = bus.wr_en && !full_w && !bus.clear;
    rd_acc    = bus.rd_en && !empty_w && !bus.clear;
    mem_words = cnt - {{ADDR_WIDTH{1'b0}}, vld_q};
    if (FWFT != 0) begin
      ren     = (mem_words != '0) && (!vld_q || rd_acc) && !bus.clear;
      vld_nxt = ren ? 1'b1 : (rd_acc ? 1'b0 : vld_q);
    end else begin
      ren     = rd_acc;
      vld_nxt = rd_acc;
    end
  end

  // Pointers, occupancy and sticky flags; clear outranks every request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (bus.clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (ren)    rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + (ADDR_WIDTH+1)'(1);
        2'b01:   cnt <= cnt - (ADDR_WIDTH+1)'(1);
        default: cnt <= cnt;
      endcase
      vld_q <= vld_nxt;
      if (bus.wr_en && full_w)  ovf_q <= 1'b1;
      if (bus.rd_en && empty_w) udf_q <= 1'b1;
    end
  end

  // RAM write port; read address never equals a same-cycle write address while the
  // read is enabled, because the write is refused whenever the pointers coincide with data present.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  // Registered RAM read; holds its value between reads and across clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   rd_q <= '0;
    else if (ren) rd_q <= mem[rd_ptr];
  end

  assign bus.full         = full_w;
  assign bus.empty        = empty_w;
  assign bus.almost_full  = (cnt >= bus.af_thresh);
  assign bus.almost_empty = (cnt <= bus.ae_thresh);
  assign bus.count        = cnt;
  assign bus.rd_data      = rd_q;
  assign bus.rd_valid     = vld_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule
